ctrl_history_buffer: RTL and testbench

- Upstream feeder of the hierarchical FIR adder in the CBADC digital estimator.
- Collects the per-cycle N-bit control-signal vector from the analog front-end into a K-deep history.
- Every DOWNSAMPLE accepted samples, once the history is full, it freezes a snapshot of the history as S_matrix and pulses start.
- S_matrix stays stable between starts, so the multi-clock adder sees constant operands for the whole computation.

---
 rtl/ctrl_history_buffer_if.sv | 43 ++++
 rtl/ctrl_history_buffer.sv | 157 +++++++++++++++
 tb/tb_ctrl_history_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_history_buffer_if.sv
// ---------------------------------------------------------------------------
// ctrl_history_buffer_if
// Groups the data-path signals of ctrl_history_buffer.
//   master : the producer side (front-end / test driver). It drives clear,
//            s_valid and s_in, and reads the snapshot outputs.
//   slave  : the history buffer itself.
// Signals:
//   clear      synchronous flush of the history fill
//   s_valid    s_in is valid this cycle
//   s_in       N-bit control vector
//   S_matrix   K-entry snapshot, [0] newest, [K-1] oldest
//   start      one-cycle pulse announcing a new snapshot
//   frame_cnt  count of starts issued, wraps
// Optional (macro HIST_OVERRUN_DET_EN):
//   adder_busy downstream adder is still computing
//   overrun    sticky flag, a snapshot was taken while the adder was busy
// ---------------------------------------------------------------------------
interface ctrl_history_buffer_if #(
  parameter int K           = 256,
  parameter int N           = 8,
  parameter int FRAME_CNT_W = 16
) ();
  logic                   clear;
  logic                   s_valid;
  logic [N-1:0]           s_in;
  logic [N-1:0]           S_matrix [K];
  logic                   start;
  logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef HIST_OVERRUN_DET_EN
  logic                   adder_busy;
  logic                   overrun;

  modport master (output clear, s_valid, s_in, adder_busy,
                  input  S_matrix, start, frame_cnt, overrun);
  modport slave  (input  clear, s_valid, s_in, adder_busy,
                  output S_matrix, start, frame_cnt, overrun);
`else
  modport master (output clear, s_valid, s_in,
                  input  S_matrix, start, frame_cnt);
  modport slave  (input  clear, s_valid, s_in,
                  output S_matrix, start, frame_cnt);
`endif
endinterface

// File: rtl/ctrl_history_buffer.sv
// ---------------------------------------------------------------------------
// ctrl_history_buffer
// Collects the per-cycle N-bit control vector into a K-deep shift history.
// Once K samples have been accepted since reset/clear, and then every
// DOWNSAMPLE accepted samples, the post-shift history is frozen into
// S_matrix and start pulses for one cycle. S_matrix is held constant
// between starts so the multi-cycle FIR adder sees stable operands.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset (all state and outputs to 0)
//   bus    ctrl_history_buffer_if.slave (clear, s_valid, s_in, S_matrix,
//          start, frame_cnt; adder_busy/overrun when enabled)
// Optional feature: define HIST_OVERRUN_DET_EN to add adder_busy/overrun.
// ---------------------------------------------------------------------------
module ctrl_history_buffer #(
  parameter int K           = 256,
  parameter int N           = 8,
  parameter int DOWNSAMPLE  = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_history_buffer_if.slave  bus
);

  localparam int FILL_W = $clog2(K + 1);
  localparam int DEC_W  = (DOWNSAMPLE > 1) ? $clog2(DOWNSAMPLE) : 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           hist_q [K];
  logic [N-1:0]           hist_d [K];
  logic [N-1:0]           snap_q [K];
  logic [N-1:0]           snap_d [K];
  logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [DEC_W-1:0]       dec_cnt_q, dec_cnt_d;
  logic                   start_q, start_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   accept;
  logic                   trigger;
`ifdef HIST_OVERRUN_DET_EN
  logic                   overrun_q, overrun_d;
`endif

  // clear wins over s_valid: a sample presented with clear is dropped.
  assign accept = bus.s_valid && !bus.clear;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      hist_q      <= '{default: '0};
      snap_q      <= '{default: '0};
      fill_cnt_q  <= '0;
      dec_cnt_q   <= '0;
      start_q     <= 1'b0;
      frame_cnt_q <= '0;
`ifdef HIST_OVERRUN_DET_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      snap_q      <= snap_d;
      fill_cnt_q  <= fill_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      start_q     <= start_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef HIST_OVERRUN_DET_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  // Next-state logic and trigger detection.
  always_comb begin
    state_d = state_q;
    trigger = 1'b0;
    if (bus.clear) begin
      state_d = FILL;
    end else if (accept) begin
      case (state_q)
        // This accept brings the fill count to K: history is now full.
        FILL: if (fill_cnt_q == FILL_W'(K - 1)) begin
          trigger = 1'b1;
          state_d = RUN;
        end
        RUN: if (dec_cnt_q == DEC_W'(DOWNSAMPLE - 1)) begin
          trigger = 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Datapath / output next values.
  always_comb begin
    hist_d      = hist_q;
    snap_d      = snap_q;
    fill_cnt_d  = fill_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    start_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
`ifdef HIST_OVERRUN_DET_EN
    overrun_d   = overrun_q;
`endif
    if (bus.clear) begin
      // Snapshot is deliberately kept; only the fill restarts.
      hist_d      = '{default: '0};
      fill_cnt_d  = '0;
      dec_cnt_d   = '0;
      frame_cnt_d = '0;
`ifdef HIST_OVERRUN_DET_EN
      overrun_d   = 1'b0;
`endif
    end else if (accept) begin
      hist_d[0] = bus.s_in;
      for (int j = 1; j < K; j++) begin
        hist_d[j] = hist_q[j-1];
      end
      if (fill_cnt_q != FILL_W'(K)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      // dec_cnt only runs in RUN; the FILL->RUN trigger leaves it at 0.
      if (state_q == RUN && !trigger) begin
        dec_cnt_d = dec_cnt_q + 1'b1;
      end else begin
        dec_cnt_d = '0;
      end
      if (trigger) begin
        // Snapshot includes the sample accepted on this edge.
        snap_d      = hist_d;
        start_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef HIST_OVERRUN_DET_EN
        if (bus.adder_busy) begin
          overrun_d = 1'b1;
        end
`endif
      end
    end
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_snap_out
      assign bus.S_matrix[gi] = snap_q[gi];
    end
  endgenerate

  assign bus.start     = start_q;
  assign bus.frame_cnt = frame_cnt_q;
`ifdef HIST_OVERRUN_DET_EN
  assign bus.overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_ctrl_history_buffer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_history_buffer
// Directed scenarios followed by randomized traffic for ctrl_history_buffer
// (K=8, N=3, DOWNSAMPLE=4). A reference model keeps a queue of accepted
// samples and a running accept count; a negedge process compares every
// output to the model, and a few literal checks pin the model itself.
// Define HIST_OVERRUN_DET_EN to also exercise adder_busy/overrun.
// ---------------------------------------------------------------------------
module tb_ctrl_history_buffer;

  localparam int K  = 8;
  localparam int N  = 3;
  localparam int DS = 4;
  localparam int FW = 16;

  logic clk;
  logic reset;

  ctrl_history_buffer_if #(.K(K), .N(N), .FRAME_CNT_W(FW)) bus ();

  ctrl_history_buffer #(.K(K), .N(N), .DOWNSAMPLE(DS), .FRAME_CNT_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // ---- reference model -------------------------------------------------
  int unsigned m_hist[$];   // [0] newest; zero-padded to K after a flush
  int unsigned m_snap[K];
  int          m_acc;       // samples accepted since last reset/clear
  bit          m_start;
  int unsigned m_frame;
  bit          m_overrun;

  task automatic model_flush(bit keep_snap);
    m_hist.delete();
    for (int i = 0; i < K; i++) m_hist.push_back(0);
    if (!keep_snap) for (int i = 0; i < K; i++) m_snap[i] = 0;
    m_acc     = 0;
    m_start   = 1'b0;
    m_frame   = 0;
    m_overrun = 1'b0;
  endtask

  task automatic model_step(bit clr, bit v, logic [N-1:0] din, bit busy);
    m_start = 1'b0;
    if (clr) begin
      model_flush(1'b1);
    end else if (v) begin
      m_hist.push_front(int'(din));
      void'(m_hist.pop_back());
      m_acc++;
      // First snapshot after K accepts, then one every DS accepts.
      if (m_acc == K || (m_acc > K && ((m_acc - K) % DS) == 0)) begin
        for (int i = 0; i < K; i++) m_snap[i] = m_hist[i];
        m_start = 1'b1;
        m_frame = (m_frame + 1) % (1 << FW);
        if (busy) m_overrun = 1'b1;
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " start"}, int'(bus.start), 0);
    chk({tag, " frame_cnt"}, int'(bus.frame_cnt), 0);
    for (int i = 0; i < K; i++)
      chk($sformatf("%s S_matrix[%0d]", tag, i), int'(bus.S_matrix[i]), 0);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start", int'(bus.start), int'(m_start));
      chk("frame_cnt", int'(bus.frame_cnt), int'(m_frame));
      for (int i = 0; i < K; i++)
        chk($sformatf("S_matrix[%0d]", i), int'(bus.S_matrix[i]), int'(m_snap[i]));
`ifdef HIST_OVERRUN_DET_EN
      chk("overrun", int'(bus.overrun), int'(m_overrun));
`endif
    end
  end

  // ---- stimulus helpers ------------------------------------------------
  task automatic drive(bit clr, bit v, logic [N-1:0] din, bit busy);
    bus.clear   = clr;
    bus.s_valid = v;
    bus.s_in    = din;
`ifdef HIST_OVERRUN_DET_EN
    bus.adder_busy = busy;
`endif
    @(posedge clk);
    #1;
    model_step(clr, v, din, busy);
    $display("[TB] t=%0t clr=%0b v=%0b in=%0d busy=%0b -> start=%0b frame=%0d",
             $time, clr, v, din, busy, bus.start, bus.frame_cnt);
  endtask

  // Entered just after a rising edge; reset is raised and dropped
  // between edges.
  task automatic async_reset();
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    reset = 1'b1;
    model_flush(1'b0);
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    $display("[TB] t=%0t async reset pulse", $time);
  endtask

  initial begin
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_in    = '0;
`ifdef HIST_OVERRUN_DET_EN
    bus.adder_busy = 1'b0;
`endif
    model_flush(1'b0);
    reset = 1'b1;
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1) Fill with 1..7,0.
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, N'(i % 8), 1'b0);
    chk("fill start", int'(bus.start), 1);
    chk("fill frame_cnt", int'(bus.frame_cnt), 1);
    for (int i = 0; i < K; i++)
      chk($sformatf("fill S_matrix[%0d]", i), int'(bus.S_matrix[i]), (8 - i) % 8);

    // 2) Four more accepts: 5,5,5,2. Oldest of the last eight is the 5th input (5).
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    chk("run pre start", int'(bus.start), 0);
    drive(1'b0, 1'b1, 3'd2, 1'b0);
    chk("run start", int'(bus.start), 1);
    chk("run frame_cnt", int'(bus.frame_cnt), 2);
    chk("run S_matrix[0]", int'(bus.S_matrix[0]), 2);
    chk("run S_matrix[3]", int'(bus.S_matrix[3]), 5);
    chk("run S_matrix[4]", int'(bus.S_matrix[4]), 0);
    chk("run S_matrix[7]", int'(bus.S_matrix[7]), 5);

    // 3) s_valid toggling: start only after the 4th accept.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i % 2) == 0, N'(i), 1'b0);
      if (i == 6) chk("toggle start", int'(bus.start), 1);
      if (i == 5) chk("toggle no start", int'(bus.start), 0);
    end
    chk("toggle frame_cnt", int'(bus.frame_cnt), 3);

    // 4) Two accepts, then clear with s_valid=1.
    drive(1'b0, 1'b1, 3'd1, 1'b0);
    drive(1'b0, 1'b1, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 3'd7, 1'b0);
    chk("clear frame_cnt", int'(bus.frame_cnt), 0);
    chk("clear keeps S_matrix[0]", int'(bus.S_matrix[0]), 6);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, N'(i), 1'b0);
      if (i == 6) chk("refill no start", int'(bus.start), 0);
    end
    chk("refill start", int'(bus.start), 1);
    chk("refill frame_cnt", int'(bus.frame_cnt), 1);
    chk("refill S_matrix[0]", int'(bus.S_matrix[0]), 7);
    chk("refill S_matrix[7]", int'(bus.S_matrix[7]), 0);

    // 5) Async reset mid-RUN, then a full refill.
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, N'(i + 3), 1'b0);
    async_reset();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, N'(7 - i), 1'b0);
    chk("post reset frame_cnt", int'(bus.frame_cnt), 1);
    chk("post reset S_matrix[0]", int'(bus.S_matrix[0]), 0);

`ifdef HIST_OVERRUN_DET_EN
    // 6) Trigger while the adder is busy.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, N'(i), 1'b0);
    chk("ovr before", int'(bus.overrun), 0);
    drive(1'b0, 1'b1, 3'd4, 1'b1);
    chk("ovr start", int'(bus.start), 1);
    chk("ovr set", int'(bus.overrun), 1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, N'(i), 1'b0);
    chk("ovr sticky", int'(bus.overrun), 1);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    chk("ovr cleared", int'(bus.overrun), 0);
`endif

    // 7) Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) async_reset();
      else drive(r < 5, $urandom_range(0, 3) != 0, N'($urandom), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
